// File: rtl/mul_share_ctrl.sv
// Shared iterative shift-add unsigned multiplier with round-robin arbitration
// between two requesters. Optional early termination: define EARLY_TERM_EN.
module mul_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_id,
    output logic [2*WIDTH-1:0]   out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state, state_nx;
    logic                 ptr;
    logic                 grant;
    logic                 take;
    logic                 last_iter;
    logic                 id_q;
    logic [WIDTH-1:0]     sel_a, sel_b;
    logic [2*WIDTH-1:0]   mcand, prod;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = ptr;
        if (req0_valid && !req1_valid) grant = 1'b0;
        else if (req1_valid && !req0_valid) grant = 1'b1;
    end

    assign take       = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = take && !grant;
    assign req1_ready = take && grant;
    assign sel_a      = grant ? req1_a : req0_a;
    assign sel_b      = grant ? req1_b : req0_b;

`ifdef EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= 1'b0;
            id_q   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        mcand  <= {{WIDTH{1'b0}}, sel_a};
                        mplier <= sel_b;
                        prod   <= '0;
                        cnt    <= '0;
                        id_q   <= grant;
                        ptr    <= ~grant;
                    end
                end
                RUN: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign out_id    = id_q;
    assign out_data  = prod;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Randomized self-checking bench for mul_share_ctrl against an arithmetic
// reference model (product = a*b, round-robin pointer, latency from b).
module tb_mul_share_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic              out_valid, out_id, busy;
    logic              out_ready = 1'b0;
    logic [2*WIDTH-1:0] out_data;

    int errors = 0;
    int checks = 0;
    bit m_ptr  = 1'b0;

    mul_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle (counted from the handshake cycle 0) in which out_valid first rises.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef EARLY_TERM_EN
        int h;
        h = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) h = i;
        return h + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic run_op(input bit v0, input bit v1,
                          input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                          input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                          input bit keep, input int hold, input bit rdy_early);
        bit g;
        int cyc;
        logic [WIDTH-1:0] ea, eb;
        logic [63:0] exp;
        g   = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : m_ptr;
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        exp = 64'(ea) * 64'(eb);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        out_ready  = rdy_early;
        #1;
        check("grant_rdy0", 64'(req0_ready), 64'(!g));
        check("grant_rdy1", 64'(req1_ready), 64'(g));
        m_ptr = !g;
        step();
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_a = $urandom; req0_b = $urandom;
        req1_a = $urandom; req1_b = $urandom;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (cyc == 1) begin
                check("busy_run", 64'(busy), 64'd1);
                check("rdy_run", {62'd0, req1_ready, req0_ready}, 64'd0);
            end
            step();
            cyc++;
        end
        check("latency", 64'(cyc), 64'(exp_lat(eb)));
        check("data", out_data, exp);
        check("id", 64'(out_id), 64'(g));
        if (!rdy_early) begin
            for (int i = 0; i < hold; i++) begin
                step();
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, exp);
                check("hold_rdy", {62'd0, req1_ready, req0_ready}, 64'd0);
            end
            out_ready = 1'b1;
        end
        step();
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("busy_drop", 64'(busy), 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2, 3:    return WIDTH'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        run_op(1, 0, 32'd3, 32'd5, 32'd0, 32'd0, 0, 0, 0);
        run_op(0, 1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);

        for (int n = 0; n < 4; n++)
            run_op(1, 1, WIDTH'(n + 1), 32'd2, WIDTH'(n + 1), 32'd2, 1, 0, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        run_op(1, 0, $urandom, $urandom, 32'd0, 32'd0, 0, 10, 0);

        // Abort mid-RUN after req0 moved the pointer to 1; reset must return it to 0.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'hFFFF_FFFF;
        step();
        req0_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_data", out_data, 64'd0);
        check("abort_id", 64'(out_id), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) step();
        check("abort_no_valid", 64'(out_valid), 64'd0);
        run_op(1, 1, 32'd6, 32'd7, 32'd11, 32'd13, 0, 0, 0);

`ifdef EARLY_TERM_EN
        run_op(1, 0, 32'd7, 32'h10, 32'd0, 32'd0, 0, 0, 0);
        run_op(1, 0, 32'd7, 32'd0, 32'd0, 32'd0, 0, 0, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_op(v0, v1, rand_opnd(), rand_opnd(), rand_opnd(), rand_opnd(),
                   1'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
